// File: rtl/cpu_defs.sv
// Shared CPU encodings: load types, writeback select codes, W-stage register layout.
// Pure definitions, no state.
package cpu_defs;

  typedef enum logic [2:0] {
    LD_LW  = 3'b000,
    LD_LB  = 3'b001,
    LD_LBU = 3'b010,
    LD_LH  = 3'b011,
    LD_LHU = 3'b100
  } ld_type_e;

  typedef enum logic [1:0] {
    WD_ANS   = 2'b00,
    WD_RDATA = 2'b01,
    WD_ADDER = 2'b10
  } wd_sel_e;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] ans;
    logic [31:0] rdata;
    logic [4:0]  a3;
    logic        reg_write;
    logic        is_jal;
    logic [1:0]  s_wdata;
    logic [2:0]  ld_type;
    logic        valid;
  } w_regs_t;

  // Bubble: every field cleared except the PC, which parks at the reset vector.
  function automatic w_regs_t w_bubble(input logic [31:0] pc);
    w_regs_t b;
    b    = '0;
    b.pc = pc;
    return b;
  endfunction

  // Writeback data select; an unused code falls back to the ALU result.
  function automatic logic [31:0] wb_mux(input logic [1:0]  sel,
                                         input logic [31:0] ans,
                                         input logic [31:0] rdata,
                                         input logic [31:0] adder);
    case (sel)
      WD_RDATA: return rdata;
      WD_ADDER: return adder;
      default:  return ans;
    endcase
  endfunction

endpackage

// File: rtl/w_load_ext.sv
// Load extension: picks byte/halfword from an aligned word and sign/zero extends.
// Latency: combinational. Backpressure: none.
module w_load_ext
  import cpu_defs::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [2:0]  ld_type,
  output logic [31:0] data
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    sel_byte = 8'h00;
    case (offset)
      2'd0: sel_byte = word[7:0];
      2'd1: sel_byte = word[15:8];
      2'd2: sel_byte = word[23:16];
      2'd3: sel_byte = word[31:24];
      default: sel_byte = 8'h00;
    endcase
    // Halfword loads use only offset[1]; offset[0] is ignored on purpose.
    sel_half = offset[1] ? word[31:16] : word[15:0];
  end

  always_comb begin
    data = word;
    case (ld_type)
      LD_LB:   data = {{24{sel_byte[7]}}, sel_byte};
      LD_LBU:  data = {24'h0, sel_byte};
      LD_LH:   data = {{16{sel_half[15]}}, sel_half};
      LD_LHU:  data = {16'h0, sel_half};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/m_w_reg.sv
// M->W pipeline register with load extension on the W side; optional retire counter (W_TRACE_EN).
// Latency: 1 cycle capture, W_Rdata combinational from stored word. Backpressure: en=0 holds, clr inserts a bubble.
module m_w_reg
  import cpu_defs::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        clr,
  input  logic [31:0] M_pc,
  input  logic [31:0] M_instr,
  input  logic [31:0] M_ans,
  input  logic [31:0] M_Rdata,
  input  logic [4:0]  M_A3,
  input  logic        M_RegWrite,
  input  logic        M_is_jal,
  input  logic [1:0]  M_s_Wdata,
  input  logic [2:0]  M_ld_type,
  output logic [31:0] W_pc,
  output logic [31:0] W_instr,
  output logic [31:0] W_ans,
  output logic [31:0] W_adder,
  output logic [31:0] W_Rdata,
  output logic [4:0]  W_A3,
  output logic        W_RegWrite,
  output logic        W_is_jal,
  output logic        W_valid,
  output logic [1:0]  s_W_Wdata
`ifdef W_TRACE_EN
  ,
  output logic [31:0] W_retired
`endif
);

  w_regs_t w_q;
  w_regs_t m_d;

  always_comb begin
    m_d           = '0;
    m_d.pc        = M_pc;
    m_d.instr     = M_instr;
    m_d.ans       = M_ans;
    m_d.rdata     = M_Rdata;
    m_d.a3        = M_A3;
    // Writes to r0 are dropped here so W never asserts a write for it.
    m_d.reg_write = M_RegWrite && (M_A3 != 5'd0);
    m_d.is_jal    = M_is_jal;
    m_d.s_wdata   = M_s_Wdata;
    m_d.ld_type   = M_ld_type;
    m_d.valid     = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      w_q <= w_bubble(RESET_PC);
    else if (clr)   w_q <= w_bubble(RESET_PC);
    else if (en)    w_q <= m_d;
  end

  assign W_pc       = w_q.pc;
  assign W_instr    = w_q.instr;
  assign W_ans      = w_q.ans;
  assign W_adder    = w_q.pc;
  assign W_A3       = w_q.a3;
  assign W_RegWrite = w_q.reg_write;
  assign W_is_jal   = w_q.is_jal;
  assign W_valid    = w_q.valid;
  assign s_W_Wdata  = w_q.s_wdata;

  w_load_ext u_load_ext (
    .word    (w_q.rdata),
    .offset  (w_q.ans[1:0]),
    .ld_type (w_q.ld_type),
    .data    (W_Rdata)
  );

`ifdef W_TRACE_EN
  logic [31:0] retired_q;

  // Counts instructions leaving W: a valid entry advanced by en, clr or not.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                retired_q <= 32'h0;
    else if (w_q.valid && en) retired_q <= retired_q + 32'd1;
  end

  assign W_retired = retired_q;
`endif

endmodule

// File: doc/m_w_reg.md
M_W_REG -- requirements
Module: m_w_reg

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_3000, value of W_pc after reset or clear.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 en  input  1  capture enable; 0 holds all registers.
REQ-005 clr  input  1  synchronous bubble insert; overrides en.
REQ-006 M_pc  input  32  M-stage instruction PC.
REQ-007 M_instr  input  32  M-stage instruction word.
REQ-008 M_ans  input  32  M-stage ALU/MD result; also the memory address.
REQ-009 M_Rdata  input  32  raw aligned word from data memory.
REQ-010 M_A3  input  5  destination register.
REQ-011 M_RegWrite  input  1  register write request.
REQ-012 M_is_jal  input  1  link instruction flag.
REQ-013 M_s_Wdata  input  2  writeback select: 00 ans, 01 Rdata, 10 adder.
REQ-014 M_ld_type  input  3  000 lw, 001 lb, 010 lbu, 011 lh, 100 lhu.
REQ-015 W_pc, W_instr, W_ans, W_adder  output  32 each  registered W-stage values; W_adder equals W_pc.
REQ-016 W_Rdata  output  32  load data after extension.
REQ-017 W_A3  output  5; W_RegWrite, W_is_jal, W_valid  output  1 each; s_W_Wdata  output  2.

Function
REQ-018 Priority per edge SHALL be: reset, then clr, then en, then hold.
REQ-019 On capture, every W_* register SHALL take its M_* counterpart one cycle after the edge, and W_valid SHALL be set to 1.
REQ-020 On capture with M_A3==0, W_RegWrite SHALL be stored as 0.
REQ-021 On clr, the block SHALL load a bubble: W_pc=RESET_PC, all other registers 0, W_valid=0.
REQ-022 Stored load type and raw word SHALL be registered; W_Rdata SHALL be computed combinationally from them and W_ans[1:0].
REQ-023 lb/lbu SHALL select byte W_ans[1:0] (0 = bits 7:0), then sign-extend or zero-extend it.
REQ-024 lh/lhu SHALL select the halfword given by W_ans[1], ignoring W_ans[0], then sign-extend or zero-extend it.
REQ-025 lw and undefined ld_type codes (101-111) SHALL pass the raw word unchanged.
REQ-026 With en=0 and clr=0, all outputs SHALL hold exactly, including W_Rdata.

Reset
REQ-027 Asserting reset SHALL immediately, without a clock edge, force the bubble values of REQ-021.
REQ-028 Reset asserted mid-capture SHALL win; releasing reset SHALL take effect on the next rising edge, with no partial capture.

Configuration
REQ-029 With W_TRACE_EN defined, the block SHALL add output W_retired (32 bits), reset to 0, which increments, wrapping, on each edge where W_valid==1 and en==1.
REQ-030 Without W_TRACE_EN, the W_retired port and its counter SHALL NOT exist.

Structure
REQ-031 Load-type codes and writeback-select codes SHALL live in shared package/header cpu_defs, reused by the writeback mux.
REQ-032 Extension logic SHALL be sub-module w_load_ext (inputs: word, offset, type; output: data).

Verification
REQ-033 Reset asserted mid-cycle -> outputs zero immediately and W_pc=32'h0000_3000 before the next edge.
REQ-034 Capture M_ans=32'h0000_0003, M_Rdata=32'h80FF_7F01, type lb -> W_Rdata=32'hFFFF_FF80; same inputs with type lbu -> W_Rdata=32'h0000_0080.
REQ-035 Capture M_ans=2, M_Rdata=32'h8001_1234, type lh -> W_Rdata=32'hFFFF_8001; type lhu with ans=0 -> W_Rdata=32'h0000_1234.
REQ-036 Capture with M_A3=0 and M_RegWrite=1 -> W_RegWrite=0; capture with M_A3=31 and is_jal=1 -> W_RegWrite=1, W_adder=M_pc.
REQ-037 Hold en=0 for 3 cycles while inputs change -> outputs frozen; clr=1 together with en=1 -> bubble, W_valid=0.
REQ-038 With W_TRACE_EN: 5 valid captures, then 1 clr, then 2 holds -> W_retired=5; counter preset to 32'hFFFF_FFFF wraps to 0 on the next valid capture.
